// File: rtl/fixed_point_pkg.sv
// Shared Q15.10 format constants for the calculator core and the display path.
// Constants only: no latency, no flow control.
package fixed_point_pkg;

   localparam int FRACTION_BITS = 10;
   localparam int DATA_WIDTH    = 25;
   localparam int INT_BITS      = DATA_WIDTH - FRACTION_BITS;
   localparam int BCD_WIDTH     = 19;
   localparam int DIGITS        = 5;

endpackage

// File: rtl/fixed_point_display_split_int_to_bcd.sv
// Binary-to-packed-BCD (shift-add-3) with a significant-digit count.
// Combinational: zero latency, no flow control.
module int_to_bcd
   import fixed_point_pkg::*;
(
   input  logic [INT_BITS-1:0]  bin_int,
   output logic [BCD_WIDTH-1:0] bcd,
   output logic [2:0]           int_digits
);

   logic [BCD_WIDTH-1:0] acc;

   // The ten-thousands digit never exceeds 1, so it never needs the +3
   // correction, and its top bit is always 0 before each shift.
   always_comb begin
      acc = '0;
      for (int i = INT_BITS - 1; i >= 0; i--) begin
         for (int d = 0; d < DIGITS - 1; d++) begin
            if (acc[4*d +: 4] >= 4'd5)
               acc[4*d +: 4] = acc[4*d +: 4] + 4'd3;
         end
         acc = {acc[BCD_WIDTH-2:0], bin_int[i]};
      end
   end

   assign bcd = acc;

   always_comb begin
      int_digits = 3'd1;
      if (bcd[18:16] != 3'd0)
         int_digits = 3'd5;
      else if (bcd[15:12] != 4'd0)
         int_digits = 3'd4;
      else if (bcd[11:8] != 4'd0)
         int_digits = 3'd3;
      else if (bcd[7:4] != 4'd0)
         int_digits = 3'd2;
   end

endmodule

// File: rtl/fixed_point_display_split.sv
// Splits a signed Q15.10 value into sign, integer/fraction magnitudes and BCD digits.
// One-cycle latency, new value every cycle; no handshake, no backpressure.
module fixed_point_display_split
   import fixed_point_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic [DATA_WIDTH-1:0]    bin,
   output logic                     neg,
   output logic                     frac,
   output logic [INT_BITS-1:0]      bin_int,
   output logic [FRACTION_BITS-1:0] bin_frac,
   output logic [BCD_WIDTH-1:0]     bcd,
   output logic [2:0]               int_digits
);

   logic [DATA_WIDTH-1:0] mag;

   // Negating -2^24 yields 2^24, which read as unsigned is the correct magnitude.
   assign mag = bin[DATA_WIDTH-1] ? (~bin + DATA_WIDTH'(1)) : bin;

   always_ff @(posedge clk) begin
      if (!reset) begin
         neg      <= 1'b0;
         frac     <= 1'b0;
         bin_int  <= '0;
         bin_frac <= '0;
      end else begin
         neg      <= bin[DATA_WIDTH-1];
         frac     <= (mag[FRACTION_BITS-1:0] != '0);
         bin_int  <= mag[DATA_WIDTH-1:FRACTION_BITS];
         bin_frac <= mag[FRACTION_BITS-1:0];
      end
   end

   int_to_bcd u_int_to_bcd (
      .bin_int    (bin_int),
      .bcd        (bcd),
      .int_digits (int_digits)
   );

endmodule

// File: tb/tb_fixed_point_display_split.sv
// Directed-vector bench for fixed_point_display_split with hand-computed expectations.
module tb_fixed_point_display_split;

   logic        clk;
   logic        reset;
   logic [24:0] bin;
   logic        neg;
   logic        frac;
   logic [14:0] bin_int;
   logic [9:0]  bin_frac;
   logic [18:0] bcd;
   logic [2:0]  int_digits;

   int tests_run;
   int tests_failed;

   fixed_point_display_split dut (
      .clk        (clk),
      .reset      (reset),
      .bin        (bin),
      .neg        (neg),
      .frac       (frac),
      .bin_int    (bin_int),
      .bin_frac   (bin_frac),
      .bcd        (bcd),
      .int_digits (int_digits)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive away from the active edge, clock once, sample just after the edge.
   task automatic step(input logic [24:0] b, input logic r);
      @(negedge clk);
      bin   = b;
      reset = r;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic e_neg, input logic e_frac,
                          input logic [14:0] e_int, input logic [9:0] e_fr,
                          input logic [18:0] e_bcd, input logic [2:0] e_dig);
      chk({tag, ".neg"},        32'(neg),        32'(e_neg));
      chk({tag, ".frac"},       32'(frac),       32'(e_frac));
      chk({tag, ".bin_int"},    32'(bin_int),    32'(e_int));
      chk({tag, ".bin_frac"},   32'(bin_frac),   32'(e_fr));
      chk({tag, ".bcd"},        32'(bcd),        32'(e_bcd));
      chk({tag, ".int_digits"}, 32'(int_digits), 32'(e_dig));
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset        = 1'b0;
      bin          = 25'h0001400;

      step(25'h0001400, 1'b0);
      step(25'h0001400, 1'b0);
      chk_all("reset", 1'b0, 1'b0, 15'd0, 10'd0, 19'h00000, 3'd1);

      step(25'h0003200, 1'b1);   // 12.5
      chk_all("p12_5", 1'b0, 1'b1, 15'd12, 10'd512, 19'h00012, 3'd2);

      step(25'h1FFF300, 1'b1);   // -3.25
      chk_all("n3_25", 1'b1, 1'b1, 15'd3, 10'd256, 19'h00003, 3'd1);

      step(25'h09C3C00, 1'b1);   // 9999.0
      chk_all("p9999", 1'b0, 1'b0, 15'd9999, 10'd0, 19'h09999, 3'd4);

      step(25'h1000000, 1'b1);   // -16384.0
      chk_all("nmin", 1'b1, 1'b0, 15'd16384, 10'd0, 19'h16384, 3'd5);

      step(25'h0FFFFFF, 1'b1);   // 16383 + 1023/1024
      chk_all("pmax", 1'b0, 1'b1, 15'd16383, 10'd1023, 19'h16383, 3'd5);

      step(25'h0C0E700, 1'b1);   // 12345.75
      chk_all("p12345", 1'b0, 1'b1, 15'd12345, 10'd768, 19'h12345, 3'd5);

      step(25'h00FA000, 1'b1);   // 1000.0
      chk_all("p1000", 1'b0, 1'b0, 15'd1000, 10'd0, 19'h01000, 3'd4);

      step(25'h0019000, 1'b1);   // 100.0
      chk_all("p100", 1'b0, 1'b0, 15'd100, 10'd0, 19'h00100, 3'd3);

      step(25'h0002800, 1'b1);   // 10.0
      chk_all("p10", 1'b0, 1'b0, 15'd10, 10'd0, 19'h00010, 3'd2);

      step(25'h1FFFFFF, 1'b1);   // -1/1024
      chk_all("nlsb", 1'b1, 1'b1, 15'd0, 10'd1, 19'h00000, 3'd1);

      // Back-to-back values with reset dropped on the third edge.
      step(25'h0000000, 1'b1);
      chk_all("b2b0", 1'b0, 1'b0, 15'd0, 10'd0, 19'h00000, 3'd1);
      step(25'h00003FF, 1'b1);
      chk_all("b2b1", 1'b0, 1'b1, 15'd0, 10'd1023, 19'h00000, 3'd1);
      step(25'h1FFFFFF, 1'b0);
      chk_all("b2b2_rst", 1'b0, 1'b0, 15'd0, 10'd0, 19'h00000, 3'd1);

      // First capture after reset release uses the bin present at that edge.
      step(25'h0003200, 1'b1);
      chk_all("post_rst", 1'b0, 1'b1, 15'd12, 10'd512, 19'h00012, 3'd2);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
